// File: rtl/exec_datapath.sv
// rtl/exec_datapath.sv - execute-stage slice: Rd write-enable decoder, ALU with N/Z/C/V flags, RAM address mux
module exec_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch,
  input  logic [31:0] s1,
  input  logic [31:0] s2,
  input  logic        seladdbusmux,
  input  logic [31:0] addbusaccess,
  input  logic [31:0] pcinstruct,
  output logic [15:0] en,
  output logic [31:0] result,
  output logic        n,
  output logic        z,
  output logic        c,
  output logic        v,
  output logic [3:0]  flags_q,
  output logic [31:0] addressbus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_EOR = 4'b0100;
  localparam logic [3:0] OP_MVN = 4'b0101;
  localparam logic [3:0] OP_LSL = 4'b0110;
  localparam logic [3:0] OP_LSR = 4'b0111;
  localparam logic [3:0] OP_ASR = 4'b1000;
  localparam logic [3:0] OP_ROR = 4'b1001;
  localparam logic [3:0] OP_LDR = 4'b1010;
  localparam logic [3:0] OP_STR = 4'b1011;
  localparam logic [3:0] OP_ADC = 4'b1100;
  localparam logic [3:0] OP_SBC = 4'b1101;
  localparam logic [3:0] OP_MOV = 4'b1110;
  localparam logic [3:0] OP_RSV = 4'b1111;

  logic [3:0]  opcode;
  logic        set_flags;
  logic [3:0]  rd;
  logic [4:0]  amt;
  logic [5:0]  ror_inv;

  assign opcode    = fetch[27:24];
  assign set_flags = fetch[23];
  assign rd        = fetch[22:19];
  assign amt       = s2[4:0];
  assign ror_inv   = 6'd32 - {1'b0, amt};

  // One-hot destination write enable; always exactly one bit set
  always_comb begin
    en = 16'h0000;
    en[rd] = 1'b1;
  end

  // RAM address source: data access from memory control, otherwise instruction fetch
  assign addressbus = seladdbusmux ? addbusaccess : pcinstruct;

  // Shared adder operands: subtraction is s1 + ~s2 + carry-in, so C is no-borrow
  logic [31:0] add_b;
  logic        add_cin;
  logic [32:0] add_sum;
  logic        add_v;

  // Select adder second operand and carry-in; ADC/SBC use the stored C only
  always_comb begin
    add_b   = s2;
    add_cin = 1'b0;
    case (opcode)
      OP_SUB: begin
        add_b   = ~s2;
        add_cin = 1'b1;
      end
      OP_ADC: add_cin = flags_q[1];
      OP_SBC: begin
        add_b   = ~s2;
        add_cin = flags_q[1];
      end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, s1} + {1'b0, add_b} + {32'b0, add_cin};
  assign add_v   = (s1[31] == add_b[31]) && (add_sum[31] != s1[31]);

  // Shifts are widened by one bit so the last bit shifted out lands in the extra bit;
  // with a zero amount that bit is 0, which gives c=0 for free
  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic [32:0] asr_w;
  logic [31:0] ror_w;

  assign lsl_w = {1'b0, s1} << amt;
  assign lsr_w = {s1, 1'b0} >> amt;
  assign asr_w = $signed({s1, 1'b0}) >>> amt;
  assign ror_w = (s1 >> amt) | (s1 << ror_inv);

  // ALU result and per-operation carry/overflow
  always_comb begin
    result = 32'h0000_0000;
    c      = 1'b0;
    v      = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        result = add_sum[31:0];
        c      = add_sum[32];
        v      = add_v;
      end
      OP_AND: result = s1 & s2;
      OP_ORR: result = s1 | s2;
      OP_EOR: result = s1 ^ s2;
      OP_MVN: result = ~s2;
      OP_LSL: begin
        result = lsl_w[31:0];
        c      = lsl_w[32];
      end
      OP_LSR: begin
        result = lsr_w[32:1];
        c      = lsr_w[0];
      end
      OP_ASR: begin
        result = asr_w[32:1];
        c      = asr_w[0];
      end
      OP_ROR: begin
        result = ror_w;
        c      = (amt != 5'd0) ? ror_w[31] : 1'b0;
      end
      OP_LDR, OP_STR: result = s1;
      OP_MOV: result = s2;
      OP_RSV: result = 32'h0000_0000;
      default: result = 32'h0000_0000;
    endcase
  end

  assign n = result[31];
  assign z = (result == 32'h0000_0000);

  // Status register: loads on S for flag-capable opcodes, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (set_flags && (opcode != OP_LDR) && (opcode != OP_STR) && (opcode != OP_RSV)) begin
      flags_q <= {n, z, c, v};
    end
  end

endmodule

// File: tb/tb_exec_datapath.sv
// tb/tb_exec_datapath.sv - directed self-checking bench for exec_datapath
module tb_exec_datapath;

  logic        clk;
  logic        reset;
  logic [31:0] fetch;
  logic [31:0] s1;
  logic [31:0] s2;
  logic        seladdbusmux;
  logic [31:0] addbusaccess;
  logic [31:0] pcinstruct;
  logic [15:0] en;
  logic [31:0] result;
  logic        n, z, c, v;
  logic [3:0]  flags_q;
  logic [31:0] addressbus;

  int checks;
  int fails;

  exec_datapath dut (
    .clk(clk),
    .reset(reset),
    .fetch(fetch),
    .s1(s1),
    .s2(s2),
    .seladdbusmux(seladdbusmux),
    .addbusaccess(addbusaccess),
    .pcinstruct(pcinstruct),
    .en(en),
    .result(result),
    .n(n),
    .z(z),
    .c(c),
    .v(v),
    .flags_q(flags_q),
    .addressbus(addressbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic s, input logic [3:0] rd);
    mk = {4'b0000, op, s, rd, 19'b0};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    fetch = mk(4'b0000, 1'b1, 4'd3);
    s1 = 32'h1; s2 = 32'h2;
    seladdbusmux = 1'b0; addbusaccess = 32'h0; pcinstruct = 32'h0;
    #12;
    checks++;
    if (flags_q !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b expected %b", flags_q, 4'b0000);
    end
    checks++;
    if (en !== 16'h0008) begin
      fails++; $display("FAIL reset_en: got %h expected %h", en, 16'h0008);
    end
    checks++;
    if (result !== 32'h3) begin
      fails++; $display("FAIL reset_result: got %h expected %h", result, 32'h3);
    end
    fetch = mk(4'b0000, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_decoder();
    logic [15:0] exp;
    for (int k = 0; k < 16; k++) begin
      fetch = mk(4'b1110, 1'b0, k[3:0]);
      exp = 16'h0001 << k;
      #1;
      checks++;
      if (en !== exp) begin
        fails++; $display("FAIL decoder_rd%0d: got %h expected %h", k, en, exp);
      end
    end
  endtask

  task automatic test_addr_mux();
    seladdbusmux = 1'b0; pcinstruct = 32'h10; addbusaccess = 32'h44;
    #1;
    checks++;
    if (addressbus !== 32'h10) begin
      fails++; $display("FAIL addrmux_pc: got %h expected %h", addressbus, 32'h10);
    end
    seladdbusmux = 1'b1;
    #1;
    checks++;
    if (addressbus !== 32'h44) begin
      fails++; $display("FAIL addrmux_access: got %h expected %h", addressbus, 32'h44);
    end
  endtask

  task automatic test_add();
    fetch = mk(4'b0000, 1'b0, 4'd1);
    s1 = 32'h7FFF_FFFF; s2 = 32'h1;
    #1;
    checks++;
    if ({result, n, z, c, v} !== {32'h8000_0000, 4'b1001}) begin
      fails++; $display("FAIL add_ovf: got %h nzcv=%b expected 80000000 nzcv=1001", result, {n, z, c, v});
    end
    s1 = 32'hFFFF_FFFF; s2 = 32'h1;
    #1;
    checks++;
    if ({result, n, z, c, v} !== {32'h0, 4'b0110}) begin
      fails++; $display("FAIL add_carry: got %h nzcv=%b expected 00000000 nzcv=0110", result, {n, z, c, v});
    end
  endtask

  task automatic test_sub();
    fetch = mk(4'b0001, 1'b0, 4'd2);
    s1 = 32'd5; s2 = 32'd5;
    #1;
    checks++;
    if ({result, n, z, c, v} !== {32'h0, 4'b0110}) begin
      fails++; $display("FAIL sub_equal: got %h nzcv=%b expected 00000000 nzcv=0110", result, {n, z, c, v});
    end
    s1 = 32'd3; s2 = 32'd5;
    #1;
    checks++;
    if ({result, n, z, c, v} !== {32'hFFFF_FFFE, 4'b1000}) begin
      fails++; $display("FAIL sub_borrow: got %h nzcv=%b expected fffffffe nzcv=1000", result, {n, z, c, v});
    end
    s1 = 32'h8000_0000; s2 = 32'd1;
    #1;
    checks++;
    if ({result, n, z, c, v} !== {32'h7FFF_FFFF, 4'b0011}) begin
      fails++; $display("FAIL sub_ovf: got %h nzcv=%b expected 7fffffff nzcv=0011", result, {n, z, c, v});
    end
  endtask

  task automatic test_logic();
    fetch = mk(4'b0100, 1'b0, 4'd0);
    s1 = 32'hF0F0_00FF; s2 = 32'hFF00_00FF;
    #1;
    checks++;
    if ({result, c, v} !== {32'h0FF0_0000, 2'b00}) begin
      fails++; $display("FAIL eor: got %h cv=%b expected 0ff00000 cv=00", result, {c, v});
    end
    fetch = mk(4'b0101, 1'b0, 4'd0);
    s2 = 32'h0000_FFFF;
    #1;
    checks++;
    if ({result, n} !== {32'hFFFF_0000, 1'b1}) begin
      fails++; $display("FAIL mvn: got %h n=%b expected ffff0000 n=1", result, n);
    end
    fetch = mk(4'b1111, 1'b0, 4'd0);
    s1 = 32'd5; s2 = 32'd7;
    #1;
    checks++;
    if ({result, z} !== {32'h0, 1'b1}) begin
      fails++; $display("FAIL reserved: got %h z=%b expected 00000000 z=1", result, z);
    end
  endtask

  task automatic test_shifts();
    fetch = mk(4'b0110, 1'b0, 4'd0);
    s1 = 32'h8000_0001; s2 = 32'd1;
    #1;
    checks++;
    if ({result, c} !== {32'h0000_0002, 1'b1}) begin
      fails++; $display("FAIL lsl1: got %h c=%b expected 00000002 c=1", result, c);
    end
    s1 = 32'h0000_1234; s2 = 32'h0000_0020;
    #1;
    checks++;
    if ({result, c} !== {32'h0000_1234, 1'b0}) begin
      fails++; $display("FAIL lsl0: got %h c=%b expected 00001234 c=0", result, c);
    end
    fetch = mk(4'b0111, 1'b0, 4'd0);
    s1 = 32'h0000_0003; s2 = 32'd1;
    #1;
    checks++;
    if ({result, c} !== {32'h0000_0001, 1'b1}) begin
      fails++; $display("FAIL lsr1: got %h c=%b expected 00000001 c=1", result, c);
    end
    fetch = mk(4'b1000, 1'b0, 4'd0);
    s1 = 32'h8000_0000; s2 = 32'd4;
    #1;
    checks++;
    if ({result, c} !== {32'hF800_0000, 1'b0}) begin
      fails++; $display("FAIL asr4: got %h c=%b expected f8000000 c=0", result, c);
    end
    fetch = mk(4'b1001, 1'b0, 4'd0);
    s1 = 32'h0000_0001; s2 = 32'd1;
    #1;
    checks++;
    if ({result, n, c, v} !== {32'h8000_0000, 3'b110}) begin
      fails++; $display("FAIL ror1: got %h ncv=%b expected 80000000 ncv=110", result, {n, c, v});
    end
    s2 = 32'd0;
    #1;
    checks++;
    if ({result, c} !== {32'h0000_0001, 1'b0}) begin
      fails++; $display("FAIL ror0: got %h c=%b expected 00000001 c=0", result, c);
    end
  endtask

  task automatic test_flag_reg();
    @(negedge clk);
    fetch = mk(4'b0000, 1'b1, 4'd0);
    s1 = 32'hFFFF_FFFF; s2 = 32'd1;
    @(posedge clk); #1;
    checks++;
    if (flags_q !== 4'b0110) begin
      fails++; $display("FAIL flags_add: got %b expected %b", flags_q, 4'b0110);
    end
    @(negedge clk);
    fetch = mk(4'b1100, 1'b0, 4'd0);
    s1 = 32'd1; s2 = 32'd1;
    #1;
    checks++;
    if (result !== 32'd3) begin
      fails++; $display("FAIL adc_carry_in: got %h expected %h", result, 32'd3);
    end
    @(posedge clk); #1;
    checks++;
    if (flags_q !== 4'b0110) begin
      fails++; $display("FAIL flags_hold_s0: got %b expected %b", flags_q, 4'b0110);
    end
    @(negedge clk);
    fetch = mk(4'b1100, 1'b1, 4'd0);
    @(posedge clk); #1;
    checks++;
    if (flags_q !== 4'b0000) begin
      fails++; $display("FAIL flags_adc_s1: got %b expected %b", flags_q, 4'b0000);
    end
    @(negedge clk);
    fetch = mk(4'b1101, 1'b0, 4'd0);
    s1 = 32'd5; s2 = 32'd3;
    #1;
    checks++;
    if ({result, c} !== {32'd1, 1'b1}) begin
      fails++; $display("FAIL sbc_borrow_in: got %h c=%b expected 00000001 c=1", result, c);
    end
    fetch = mk(4'b1010, 1'b1, 4'd0);
    s1 = 32'h0; s2 = 32'h9;
    #1;
    checks++;
    if ({result, z} !== {32'h0, 1'b1}) begin
      fails++; $display("FAIL ldr_passthru: got %h z=%b expected 00000000 z=1", result, z);
    end
    s1 = 32'h8000_0000;
    @(posedge clk); #1;
    checks++;
    if (flags_q !== 4'b0000) begin
      fails++; $display("FAIL ldr_no_store: got %b expected %b", flags_q, 4'b0000);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    fetch = mk(4'b0000, 1'b1, 4'd5);
    s1 = 32'h7FFF_FFFF; s2 = 32'd1;
    @(posedge clk); #1;
    checks++;
    if (flags_q !== 4'b1001) begin
      fails++; $display("FAIL flags_1001: got %b expected %b", flags_q, 4'b1001);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (flags_q !== 4'b0000) begin
      fails++; $display("FAIL async_clear: got %b expected %b", flags_q, 4'b0000);
    end
    checks++;
    if ({en, result} !== {16'h0020, 32'h8000_0000}) begin
      fails++; $display("FAIL reset_passthru: got en=%h result=%h expected en=0020 result=80000000", en, result);
    end
    @(posedge clk); #1;
    checks++;
    if (flags_q !== 4'b0000) begin
      fails++; $display("FAIL reset_hold: got %b expected %b", flags_q, 4'b0000);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (flags_q !== 4'b1001) begin
      fails++; $display("FAIL first_edge_after_reset: got %b expected %b", flags_q, 4'b1001);
    end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    test_reset();
    test_decoder();
    test_addr_mux();
    test_add();
    test_sub();
    test_logic();
    test_shifts();
    test_flag_reg();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
